// File: rtl/cache_axi_pkg.sv
// Shared types and AXI encodings for the cache-line read bridge.
package cache_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_DONE,
        ST_RELEASE
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BEATS          = 4;

endpackage

// File: rtl/axi_rd_bridge.sv
// Cache line refill bridge: one cache read request becomes one fixed-length
// AXI INCR read burst, and the beats are assembled into a single line.
//
// state      | meaning
// IDLE       | ready for a request, latches the aligned line address
// AR         | address phase, arvalid held until arready
// R          | collecting BEATS data beats into the line buffer
// DONE       | one-cycle cache_rvalid_o pulse with the assembled line
// RELEASE    | waits for the cache to drop its request
module axi_rd_bridge
    import cache_axi_pkg::*;
#(
    parameter int         ADDR_WIDTH      = 32,
    parameter int         CACHELINE_WIDTH = 128,
    parameter int         AXI_DATA_WIDTH  = 32,
    parameter logic [3:0] AXI_ID          = 4'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cache_rreq_i,
    input  logic [ADDR_WIDTH-1:0]      cache_addr_i,
    output logic                       cache_rdy_o,
    output logic                       cache_rvalid_o,
    output logic [1:0]                 cache_rlast_o,
    output logic [CACHELINE_WIDTH-1:0] cache_data_o,
    output logic                       cache_rerr_o,
    output logic [3:0]                 arid_o,
    output logic [ADDR_WIDTH-1:0]      araddr_o,
    output logic [7:0]                 arlen_o,
    output logic [2:0]                 arsize_o,
    output logic [1:0]                 arburst_o,
    output logic                       arvalid_o,
    input  logic                       arready_i,
    input  logic [3:0]                 rid_i,
    input  logic [AXI_DATA_WIDTH-1:0]  rdata_i,
    input  logic [1:0]                 rresp_i,
    input  logic                       rlast_i,
    input  logic                       rvalid_i,
    output logic                       rready_o
);

    localparam int CNT_W = $clog2(BEATS);

    state_t                      state;
    logic [CNT_W-1:0]            beat_cnt;
    logic                        err_flag;
    logic [AXI_DATA_WIDTH-1:0]   line_q [BEATS];
    logic [CACHELINE_WIDTH-1:0]  line_next;
    logic                        last_beat;
    logic                        beat_err;
    logic                        beat_acc;
    logic                        unused_ok;

    assign arid_o    = AXI_ID;
    assign arlen_o   = 8'(BEATS - 1);
    assign arsize_o  = AXI_SIZE_4B;
    assign arburst_o = AXI_BURST_INCR;

    // ID is constant for our single outstanding burst; low address bits are forced to line alignment
    assign unused_ok = ^{rid_i, cache_addr_i[3:0]};

    assign beat_acc  = rvalid_i & rready_o;
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
    assign beat_err  = (rresp_i != AXI_RESP_OKAY) || (rlast_i != last_beat);

    // Line as it will look once the current beat lands, so DONE can publish it directly
    always_comb begin
        line_next = '0;
        for (int i = 0; i < BEATS; i++) begin
            line_next[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] =
                (beat_cnt == CNT_W'(i)) ? rdata_i : line_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            beat_cnt       <= '0;
            err_flag       <= 1'b0;
            line_q         <= '{default: '0};
            cache_rdy_o    <= 1'b1;
            cache_rvalid_o <= 1'b0;
            cache_rlast_o  <= 2'b00;
            cache_data_o   <= '0;
            cache_rerr_o   <= 1'b0;
            araddr_o       <= '0;
            arvalid_o      <= 1'b0;
            rready_o       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cache_rreq_i) begin
                        araddr_o    <= {cache_addr_i[ADDR_WIDTH-1:4], 4'b0};
                        arvalid_o   <= 1'b1;
                        cache_rdy_o <= 1'b0;
                        err_flag    <= 1'b0;
                        state       <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (arvalid_o && arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= ST_R;
                    end
                end
                ST_R: begin
                    if (beat_acc) begin
                        line_q[beat_cnt] <= rdata_i;
                        beat_cnt         <= beat_cnt + 1'b1;
                        if (beat_err) begin
                            err_flag <= 1'b1;
                        end
                        // Completion is by beat count only; a stray rlast just flags an error
                        if (last_beat) begin
                            rready_o       <= 1'b0;
                            cache_rvalid_o <= 1'b1;
                            cache_rlast_o  <= 2'b11;
                            cache_rerr_o   <= err_flag | beat_err;
                            cache_data_o   <= line_next;
                            state          <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    cache_rvalid_o <= 1'b0;
                    cache_rlast_o  <= 2'b00;
                    cache_rerr_o   <= 1'b0;
                    state          <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!cache_rreq_i) begin
                        cache_rdy_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
